// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, exception vector,
// redirect-source encoding and target alignment helper.
package pc_seq_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EXC  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_JMP  = 2'd3
    } redir_src_e;

    // Fetch addresses are word aligned; the low two bits are never honoured.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_npc_select.sv
// Combinational redirect priority select: exception > branch > jump.
// The exception source exists only when PC_SEQ_EXC_EN is defined.
module npc_select
    import pc_seq_pkg::*;
(
`ifdef PC_SEQ_EXC_EN
    input  logic        exc_req_i,
`endif
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_target_i,
    output redir_src_e  src_o,
    output logic [31:0] target_o
);

    logic [31:0] raw_target;

    always_comb begin
        src_o      = SRC_NONE;
        raw_target = '0;
`ifdef PC_SEQ_EXC_EN
        if (exc_req_i) begin
            src_o      = SRC_EXC;
            raw_target = EXC_VECTOR;
        end else
`endif
        if (br_taken_i) begin
            src_o      = SRC_BR;
            raw_target = br_target_i;
        end else if (jmp_valid_i) begin
            src_o      = SRC_JMP;
            raw_target = jmp_target_i;
        end
        target_o = align_word(raw_target);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/PEND FSM with sequential advance, stall hold,
// deferred redirects and a one-cycle flush pulse. Optional exception
// redirect enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        if_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
`ifdef PC_SEQ_EXC_EN
    input  logic        exc_req,
`endif
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        flush_q, flush_d;

    redir_src_e  redir_src;
    logic [31:0] redir_target;
    logic        redirect;

    npc_select u_npc_select (
`ifdef PC_SEQ_EXC_EN
        .exc_req_i    (exc_req),
`endif
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jmp_valid_i  (jmp_valid),
        .jmp_target_i (jmp_target),
        .src_o        (redir_src),
        .target_o     (redir_target)
    );

    assign redirect = (redir_src != SRC_NONE);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        flush_d = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // A redirect overrides stall; without a taker it is parked in PEND.
                if (redirect) begin
                    if (if_ready) begin
                        pc_d    = redir_target;
                        flush_d = 1'b1;
                    end else begin
                        pend_d  = redir_target;
                        state_d = ST_PEND;
                    end
                end else if (if_ready && !stall) begin
                    pc_d = pc_q + STEP;
                end
            end
            ST_PEND: begin
                if (redirect) begin
                    pend_d = redir_target;
                end
                if (if_ready) begin
                    pc_d    = redirect ? redir_target : pend_q;
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q != ST_BOOT);
    assign flush    = flush_q;

endmodule
